// File: rtl/vm1_tve_pkg.sv
// rtl/vm1_tve_pkg.sv - shared types and defaults for the VM1 timer bus controller
package vm1_tve_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_WAIT,
    ST_REPLY,
    ST_IAK,
    ST_REL
  } tve_state_e;

  typedef enum logic [1:0] {
    HIT_NONE,
    HIT_LIM,
    HIT_CNT,
    HIT_CSR
  } tve_hit_e;

  localparam logic [15:0] TVE_BASE_ADR    = 16'o177706;
  localparam logic [15:0] TVE_VECTOR      = 16'o000270;
  localparam int unsigned TVE_WAIT_STATES = 1;

endpackage

// File: rtl/vm1_tve_dec.sv
// rtl/vm1_tve_dec.sv - timer register address decode and byte-lane qualifier
module vm1_tve_dec
  import vm1_tve_pkg::*;
#(
  parameter logic [15:0] BASE_ADR = TVE_BASE_ADR
) (
  input  logic [15:1] adr_i,
  input  logic        lane_i,
  input  logic        wtbt_i,
  output tve_hit_e    hit_o,
  output logic        odd_byte_o
);

  localparam logic [15:0] LIM_ADR = BASE_ADR;
  localparam logic [15:0] CNT_ADR = BASE_ADR + 16'd2;
  localparam logic [15:0] CSR_ADR = BASE_ADR + 16'd4;

  // Word-address compare; bit 0 only selects the byte lane
  always_comb begin
    hit_o = HIT_NONE;
    if (adr_i == LIM_ADR[15:1]) begin
      hit_o = HIT_LIM;
    end else if (adr_i == CNT_ADR[15:1]) begin
      hit_o = HIT_CNT;
    end else if (adr_i == CSR_ADR[15:1]) begin
      hit_o = HIT_CSR;
    end
  end

  // Byte write aimed at the high (odd) byte of the word
  assign odd_byte_o = wtbt_i & lane_i;

endmodule

// File: rtl/vm1_tve_ctl.sv
// rtl/vm1_tve_ctl.sv - VM1 timer bus-cycle controller and interrupt sequencer
module vm1_tve_ctl
  import vm1_tve_pkg::*;
#(
  parameter logic [15:0] BASE_ADR    = TVE_BASE_ADR,
  parameter logic [15:0] VECTOR      = TVE_VECTOR,
  parameter int unsigned WAIT_STATES = TVE_WAIT_STATES
) (
  input  logic        tve_clk,
  input  logic        tve_reset,
  input  logic        bus_sync,
  input  logic [15:0] bus_adr,
  input  logic        bus_din,
  input  logic        bus_dout,
  input  logic        bus_wtbt,
  input  logic        bus_iako,
  output logic        bus_rply,
  output logic [15:0] bus_vec,
  output logic        bus_irq,
  input  logic        tve_irq,
  output logic        tve_ack,
  output logic        tve_csr_oe,
  output logic        tve_cnt_oe,
  output logic        tve_lim_oe,
  output logic        tve_csr_wr,
  output logic        tve_lim_wr
);

  localparam logic [2:0] WAIT_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  logic       sync_q, iako_q, sync_arm_q, iako_arm_q;
  logic       sync_rise, iako_rise;
  tve_hit_e   hit_dec, hit_q;
  logic       lane_q, odd_byte;
  tve_state_e state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       rd_q, iak_first_q;
  logic       oe_hold, iak_serve;

  logic        rply_q, rply_d, ack_q, ack_d, irq_q;
  logic [15:0] vec_q, vec_d;
  logic        lim_wr_q, lim_wr_d, csr_wr_q, csr_wr_d;
  logic        lim_oe_q, lim_oe_d, cnt_oe_q, cnt_oe_d, csr_oe_q, csr_oe_d;

  vm1_tve_dec #(.BASE_ADR(BASE_ADR)) u_dec (
    .adr_i      (bus_adr[15:1]),
    .lane_i     (lane_q),
    .wtbt_i     (bus_wtbt),
    .hit_o      (hit_dec),
    .odd_byte_o (odd_byte)
  );

  // A strobe must be seen low after reset before its rise counts
  assign sync_rise = bus_sync & ~sync_q & sync_arm_q;
  assign iako_rise = bus_iako & ~iako_q & iako_arm_q;

  // Edge detectors and their post-reset arming
  always_ff @(posedge tve_clk or posedge tve_reset) begin
    if (tve_reset) begin
      sync_q     <= 1'b0;
      iako_q     <= 1'b0;
      sync_arm_q <= 1'b0;
      iako_arm_q <= 1'b0;
    end else begin
      sync_q     <= bus_sync;
      iako_q     <= bus_iako;
      sync_arm_q <= sync_arm_q | ~bus_sync;
      iako_arm_q <= iako_arm_q | ~bus_iako;
    end
  end

  // Address latch: hit code and byte lane captured on the address strobe
  always_ff @(posedge tve_clk or posedge tve_reset) begin
    if (tve_reset) begin
      hit_q  <= HIT_NONE;
      lane_q <= 1'b0;
    end else if (sync_rise) begin
      hit_q  <= hit_dec;
      lane_q <= bus_adr[0];
    end
  end

  // State register, wait counter, read-cycle and IAK-entry flags
  always_ff @(posedge tve_clk or posedge tve_reset) begin
    if (tve_reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 3'd0;
      rd_q        <= 1'b0;
      iak_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      if (state_q == ST_ADDR) begin
        rd_q <= bus_din;
      end
      iak_first_q <= (state_q != ST_IAK) && (state_d == ST_IAK);
    end
  end

  // Next state and next registered outputs; outputs lag the state by one cycle
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 3'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (iako_rise && tve_irq) begin
          state_d = ST_IAK;
        end else if (sync_rise && (hit_dec != HIT_NONE)) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!bus_sync) begin
          state_d = ST_IDLE;
        end else if (bus_din) begin
          state_d = ST_RD;
        end else if (bus_dout) begin
          state_d = ST_WR;
        end
      end
      ST_RD, ST_WR: begin
        state_d = (WAIT_STATES == 0) ? ST_REPLY : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_REPLY;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_REPLY: begin
        if (!bus_din && !bus_dout) begin
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (!bus_sync) begin
          state_d = ST_IDLE;
        end
      end
      ST_IAK: begin
        if ((iak_first_q && !tve_irq) || !bus_iako) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    oe_hold   = rd_q && ((state_q == ST_RD) || (state_q == ST_WAIT) ||
                         (state_q == ST_REPLY) || (state_q == ST_REL)) &&
                !((state_q == ST_REL) && !bus_sync);
    iak_serve = (state_q == ST_IAK) && bus_iako && (!iak_first_q || tve_irq);

    lim_wr_d = (state_q == ST_WR) && (hit_q == HIT_LIM);
    csr_wr_d = (state_q == ST_WR) && (hit_q == HIT_CSR) && !odd_byte;
    lim_oe_d = oe_hold && (hit_q == HIT_LIM);
    cnt_oe_d = oe_hold && (hit_q == HIT_CNT);
    csr_oe_d = oe_hold && (hit_q == HIT_CSR);
    rply_d   = ((state_q == ST_REPLY) && (bus_din || bus_dout)) || iak_serve;
    vec_d    = iak_serve ? VECTOR : 16'd0;
    ack_d    = (state_q == ST_IAK) && iak_first_q && tve_irq;
  end

  // Output registers; reset clears them immediately
  always_ff @(posedge tve_clk or posedge tve_reset) begin
    if (tve_reset) begin
      rply_q   <= 1'b0;
      vec_q    <= 16'd0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
      lim_wr_q <= 1'b0;
      csr_wr_q <= 1'b0;
      lim_oe_q <= 1'b0;
      cnt_oe_q <= 1'b0;
      csr_oe_q <= 1'b0;
    end else begin
      rply_q   <= rply_d;
      vec_q    <= vec_d;
      ack_q    <= ack_d;
      irq_q    <= tve_irq;
      lim_wr_q <= lim_wr_d;
      csr_wr_q <= csr_wr_d;
      lim_oe_q <= lim_oe_d;
      cnt_oe_q <= cnt_oe_d;
      csr_oe_q <= csr_oe_d;
    end
  end

  assign bus_rply   = rply_q;
  assign bus_vec    = vec_q;
  assign bus_irq    = irq_q;
  assign tve_ack    = ack_q;
  assign tve_lim_wr = lim_wr_q;
  assign tve_csr_wr = csr_wr_q;
  assign tve_lim_oe = lim_oe_q;
  assign tve_cnt_oe = cnt_oe_q;
  assign tve_csr_oe = csr_oe_q;

endmodule

// File: tb/tb_vm1_tve_ctl.sv
// tb/tb_vm1_tve_ctl.sv - self-checking bench for vm1_tve_ctl
module tb_vm1_tve_ctl;

  localparam logic [15:0] BASE = 16'o177706;
  localparam logic [15:0] VEC  = 16'o000270;
  localparam int          WS   = 1;
  localparam int K_RD = 0, K_WR = 1, K_IAK = 2;

  logic        tve_clk = 1'b0, tve_reset = 1'b1;
  logic        bus_sync = 0, bus_din = 0, bus_dout = 0, bus_wtbt = 0, bus_iako = 0, tve_irq = 0;
  logic [15:0] bus_adr = '0;
  logic        bus_rply, bus_irq, tve_ack;
  logic [15:0] bus_vec;
  logic        tve_csr_oe, tve_cnt_oe, tve_lim_oe, tve_csr_wr, tve_lim_wr;

  int total = 0, bad = 0;

  typedef struct {
    int n_lim_wr; int n_csr_wr; int wr_at;
    int n_lim_oe; int n_cnt_oe; int n_csr_oe; int oe_at;
    int n_rply; int rply_at; int n_ack; int ack_at;
    int onehot; int vec_ok; int irq_ok;
  } res_t;

  typedef struct {
    int kind; logic [15:0] adr; bit wtbt; bit irq; res_t exp;
  } vec_t;

  vm1_tve_ctl #(.BASE_ADR(BASE), .VECTOR(VEC), .WAIT_STATES(WS)) dut (
    .tve_clk(tve_clk), .tve_reset(tve_reset), .bus_sync(bus_sync), .bus_adr(bus_adr),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_wtbt(bus_wtbt), .bus_iako(bus_iako),
    .bus_rply(bus_rply), .bus_vec(bus_vec), .bus_irq(bus_irq), .tve_irq(tve_irq),
    .tve_ack(tve_ack), .tve_csr_oe(tve_csr_oe), .tve_cnt_oe(tve_cnt_oe),
    .tve_lim_oe(tve_lim_oe), .tve_csr_wr(tve_csr_wr), .tve_lim_wr(tve_lim_wr)
  );

  always #5 tve_clk = ~tve_clk;

  task automatic step();
    @(posedge tve_clk);
    @(negedge tve_clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_or();
    return int'(bus_rply | (|bus_vec) | bus_irq | tve_ack | tve_csr_oe | tve_cnt_oe |
                tve_lim_oe | tve_csr_wr | tve_lim_wr);
  endfunction

  function automatic res_t mk(int lw, int cw, int wa, int lo, int co, int so, int oa,
                              int nr, int ra, int na, int aa);
    res_t r;
    r.n_lim_wr = lw; r.n_csr_wr = cw; r.wr_at = wa;
    r.n_lim_oe = lo; r.n_cnt_oe = co; r.n_csr_oe = so; r.oe_at = oa;
    r.n_rply = nr; r.rply_at = ra; r.n_ack = na; r.ack_at = aa;
    r.onehot = 1; r.vec_ok = 1; r.irq_ok = 1;
    return r;
  endfunction

  // Reference: register offset from the base picks the target; strobe/enable
  // appear two samples after the data strobe, reply WS+1 samples after that,
  // the read enable lasts until the sample where SYNC is released.
  function automatic res_t model(int kind, logic [15:0] adr, bit wtbt, bit irq);
    res_t r;
    int   off;
    r = mk(0, 0, -1, 0, 0, 0, -1, 0, -1, 0, -1);
    if (kind == K_IAK) begin
      if (irq) begin
        r.n_ack = 1; r.ack_at = 2; r.n_rply = 2; r.rply_at = 2;
      end
    end else begin
      off = int'({adr[15:1], 1'b0}) - int'(BASE);
      if (off == 0 || off == 2 || off == 4) begin
        r.n_rply = 1; r.rply_at = 2 + WS + 1;
        if (kind == K_RD) begin
          r.oe_at = 2;
          if (off == 0) r.n_lim_oe = WS + 3;
          if (off == 2) r.n_cnt_oe = WS + 3;
          if (off == 4) r.n_csr_oe = WS + 3;
        end else if (off == 0) begin
          r.n_lim_wr = 1; r.wr_at = 2;
        end else if (off == 4 && !(wtbt && adr[0])) begin
          r.n_csr_wr = 1; r.wr_at = 2;
        end
      end
    end
    return r;
  endfunction

  task automatic observe(input int k, input int kind, inout res_t r);
    int hot;
    hot = int'(tve_lim_wr) + int'(tve_csr_wr) + int'(tve_lim_oe) + int'(tve_cnt_oe) + int'(tve_csr_oe);
    if (hot > 1) r.onehot = 0;
    if (tve_lim_wr) begin r.n_lim_wr++; if (r.wr_at < 0) r.wr_at = k; end
    if (tve_csr_wr) begin r.n_csr_wr++; if (r.wr_at < 0) r.wr_at = k; end
    if (tve_lim_oe) begin r.n_lim_oe++; if (r.oe_at < 0) r.oe_at = k; end
    if (tve_cnt_oe) begin r.n_cnt_oe++; if (r.oe_at < 0) r.oe_at = k; end
    if (tve_csr_oe) begin r.n_csr_oe++; if (r.oe_at < 0) r.oe_at = k; end
    if (bus_rply)   begin r.n_rply++;   if (r.rply_at < 0) r.rply_at = k; end
    if (tve_ack)    begin r.n_ack++;    if (r.ack_at < 0) r.ack_at = k; end
    if (bus_vec !== ((kind == K_IAK && bus_rply) ? VEC : 16'd0)) r.vec_ok = 0;
  endtask

  task automatic run_txn(input int kind, input logic [15:0] adr, input bit wtbt,
                         input bit irq, output res_t r);
    bit strobe_up;
    int drop_k;
    r = mk(0, 0, -1, 0, 0, 0, -1, 0, -1, 0, -1);
    tve_irq = irq; bus_adr = adr; bus_wtbt = wtbt;
    step();
    if (kind == K_IAK) begin
      bus_iako = 1;
    end else begin
      bus_sync = 1;
      step();
      if (kind == K_RD) bus_din = 1; else bus_dout = 1;
    end
    strobe_up = 1; drop_k = -10;
    for (int k = 1; k <= 12; k++) begin
      step();
      observe(k, kind, r);
      if (kind == K_IAK) begin
        if (k == 3) bus_iako = 0;
      end else if (strobe_up && (bus_rply || k == 8)) begin
        bus_din = 0; bus_dout = 0; strobe_up = 0; drop_k = k;
      end else if (!strobe_up && k == drop_k + 1) begin
        bus_sync = 0;
      end
    end
    r.irq_ok = int'(bus_irq == irq);
    bus_wtbt = 0;
    step();
  endtask

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    chk({tag, ".n_lim_wr"}, a.n_lim_wr, e.n_lim_wr);
    chk({tag, ".n_csr_wr"}, a.n_csr_wr, e.n_csr_wr);
    chk({tag, ".wr_at"},    a.wr_at,    e.wr_at);
    chk({tag, ".n_lim_oe"}, a.n_lim_oe, e.n_lim_oe);
    chk({tag, ".n_cnt_oe"}, a.n_cnt_oe, e.n_cnt_oe);
    chk({tag, ".n_csr_oe"}, a.n_csr_oe, e.n_csr_oe);
    chk({tag, ".oe_at"},    a.oe_at,    e.oe_at);
    chk({tag, ".n_rply"},   a.n_rply,   e.n_rply);
    chk({tag, ".rply_at"},  a.rply_at,  e.rply_at);
    chk({tag, ".n_ack"},    a.n_ack,    e.n_ack);
    chk({tag, ".ack_at"},   a.ack_at,   e.ack_at);
    chk({tag, ".onehot"},   a.onehot,   e.onehot);
    chk({tag, ".vec_ok"},   a.vec_ok,   e.vec_ok);
    chk({tag, ".irq_ok"},   a.irq_ok,   e.irq_ok);
  endtask

  initial begin
    vec_t tbl[12];
    res_t r;
    int   n_bad_out, n_wr, n_rp;
    int   kind, pick;
    logic [15:0] adr;
    bit   wtbt, irq;

    tbl[0]  = '{K_WR,  16'o177706, 1'b0, 1'b0, mk(1, 0, 2, 0, 0, 0, -1, 1, 4, 0, -1)};
    tbl[1]  = '{K_RD,  16'o177712, 1'b0, 1'b1, mk(0, 0, -1, 0, 0, 4, 2, 1, 4, 0, -1)};
    tbl[2]  = '{K_WR,  16'o177713, 1'b1, 1'b0, mk(0, 0, -1, 0, 0, 0, -1, 1, 4, 0, -1)};
    tbl[3]  = '{K_WR,  16'o177710, 1'b0, 1'b0, mk(0, 0, -1, 0, 0, 0, -1, 1, 4, 0, -1)};
    tbl[4]  = '{K_WR,  16'o177714, 1'b0, 1'b0, mk(0, 0, -1, 0, 0, 0, -1, 0, -1, 0, -1)};
    tbl[5]  = '{K_IAK, 16'o000000, 1'b0, 1'b1, mk(0, 0, -1, 0, 0, 0, -1, 2, 2, 1, 2)};
    tbl[6]  = '{K_RD,  16'o177706, 1'b0, 1'b0, mk(0, 0, -1, 4, 0, 0, 2, 1, 4, 0, -1)};
    tbl[7]  = '{K_RD,  16'o177710, 1'b0, 1'b1, mk(0, 0, -1, 0, 4, 0, 2, 1, 4, 0, -1)};
    tbl[8]  = '{K_WR,  16'o177712, 1'b1, 1'b0, mk(0, 1, 2, 0, 0, 0, -1, 1, 4, 0, -1)};
    tbl[9]  = '{K_IAK, 16'o000000, 1'b0, 1'b0, mk(0, 0, -1, 0, 0, 0, -1, 0, -1, 0, -1)};
    tbl[10] = '{K_RD,  16'o177714, 1'b0, 1'b0, mk(0, 0, -1, 0, 0, 0, -1, 0, -1, 0, -1)};
    tbl[11] = '{K_WR,  16'o177712, 1'b0, 1'b1, mk(0, 1, 2, 0, 0, 0, -1, 1, 4, 0, -1)};

    // Reset state, with the interrupt input high so the irq register is exercised
    tve_irq = 1;
    step(); step();
    chk("rst.rply", int'(bus_rply), 0);
    chk("rst.vec", int'(bus_vec), 0);
    chk("rst.irq", int'(bus_irq), 0);
    chk("rst.any", outs_or(), 0);
    tve_reset = 0; tve_irq = 0;
    step(); step();

    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].kind, tbl[i].adr, tbl[i].wtbt, tbl[i].irq, r);
      cmp_res($sformatf("tbl%0d", i), r, tbl[i].exp);
    end

    // Simultaneous SYNC and IAKO rise: IAK served, register cycle ignored
    tve_irq = 1; step();
    bus_adr = BASE; bus_sync = 1; bus_iako = 1;
    step();
    bus_dout = 1;
    step();
    chk("simul.ack", int'(tve_ack), 1);
    chk("simul.vec", int'(bus_vec), int'(VEC));
    chk("simul.rply", int'(bus_rply), 1);
    bus_iako = 0;
    n_wr = 0; n_rp = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      n_wr += int'(tve_lim_wr | tve_csr_wr);
      n_rp += int'(bus_rply);
    end
    chk("simul.no_wr", n_wr, 0);
    chk("simul.no_rply", n_rp, 0);
    bus_dout = 0; bus_sync = 0; step(); step();

    // Interrupt withdrawn on the first IAK cycle: no ack, no reply
    tve_irq = 1; step();
    bus_iako = 1;
    step();
    tve_irq = 0;
    n_wr = 0; n_rp = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_wr += int'(tve_ack);
      n_rp += int'(bus_rply);
    end
    chk("iakdrop.ack", n_wr, 0);
    chk("iakdrop.rply", n_rp, 0);
    bus_iako = 0; step(); step();

    // Reset in the middle of a read
    bus_adr = BASE + 16'd4; bus_sync = 1;
    step();
    bus_din = 1;
    step(); step();
    chk("midrst.oe_before", int'(tve_csr_oe), 1);
    tve_reset = 1;
    #1;
    chk("midrst.async_clear", outs_or(), 0);
    step();
    tve_reset = 0;
    n_bad_out = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_bad_out += outs_or();
    end
    chk("midrst.stay_idle", n_bad_out, 0);
    bus_din = 0; bus_sync = 0; step(); step();

    // Randomised transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      pick = int'($urandom_range(0, 7));
      adr  = (pick < 6) ? BASE + 16'(pick) : 16'($urandom);
      wtbt = 1'($urandom_range(0, 1));
      irq  = 1'($urandom_range(0, 1));
      run_txn(kind, adr, wtbt, irq, r);
      cmp_res($sformatf("rnd%0d", i), r, model(kind, adr, wtbt, irq));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
